// File: rtl/copperv_data_responder_pkg.sv
// -----------------------------------------------------------------------------
// copperv_data_responder_pkg
// Shared types for the CPU data-bus responder:
//   bus_resp_state_e   - state of each responder channel FSM (idle / busy)
//   data_write_resp_e  - status returned on the write-response channel
// -----------------------------------------------------------------------------
package copperv_data_responder_pkg;

   typedef enum logic {
      bus_resp_idle = 1'b0,
      bus_resp_busy = 1'b1
   } bus_resp_state_e;

   typedef enum logic {
      data_write_resp_fail = 1'b0,
      data_write_resp_ok   = 1'b1
   } data_write_resp_e;

   localparam int BYTE_WIDTH = 8;

endpackage : copperv_data_responder_pkg

// File: rtl/copperv_sram_word_array.sv
// -----------------------------------------------------------------------------
// copperv_sram_word_array
// Word-organised SRAM, one synchronous read port and one byte-strobed write
// port. Built as one independent byte-lane array per strobe bit so every lane
// maps onto a plain inferred block RAM. A read and a write to the same word on
// the same edge return the old contents (read-before-write).
//
// Ports:
//   clk          in   clock
//   i_rd_en      in   read enable; o_rd_data updates on the next edge only
//   i_rd_addr    in   read word index
//   o_rd_data    out  registered read data (holds while i_rd_en=0)
//   i_wr_en      in   write enable
//   i_wr_addr    in   write word index
//   i_wr_data    in   write data
//   i_wr_strobe  in   per-byte write enables
// -----------------------------------------------------------------------------
module copperv_sram_word_array
   import copperv_data_responder_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024,
   parameter int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH,
   parameter int MEM_AW     = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_rd_en,
   input  logic [MEM_AW-1:0]     i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   input  logic                  i_wr_en,
   input  logic [MEM_AW-1:0]     i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [STRB_WIDTH-1:0] i_wr_strobe
);

   generate
      for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
         logic [BYTE_WIDTH-1:0] r_lane_mem [MEM_DEPTH];
         logic [BYTE_WIDTH-1:0] r_lane_q;

         // Non-blocking read of the old entry gives read-before-write on
         // same-address collisions.
         always_ff @(posedge clk) begin
            if (i_wr_en && i_wr_strobe[gi]) begin
               r_lane_mem[i_wr_addr] <= i_wr_data[gi*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (i_rd_en) begin
               r_lane_q <= r_lane_mem[i_rd_addr];
            end
         end

         assign o_rd_data[gi*BYTE_WIDTH +: BYTE_WIDTH] = r_lane_q;
      end
   endgenerate

endmodule : copperv_sram_word_array

// File: rtl/copperv_data_responder.sv
// -----------------------------------------------------------------------------
// copperv_data_responder
// Memory-side responder for the CPU data bus. Serves an independent read
// channel (address -> data) and write channel (address+data -> response), each
// with at most one outstanding transaction, backed by a word SRAM.
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   dr_addr_valid/ready, dr_addr      read address channel (byte address)
//   dr_data_valid/ready, dr_data      read data channel
//   dw_data_addr_valid/ready,         write request channel
//   dw_addr, dw_data, dw_strobe
//   dw_resp_valid/ready, dw_resp      write response (data_write_resp_e)
// -----------------------------------------------------------------------------
module copperv_data_responder
   import copperv_data_responder_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int RESP_WIDTH = 1,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dr_addr_valid,
   output logic                  dr_addr_ready,
   input  logic [ADDR_WIDTH-1:0] dr_addr,
   output logic                  dr_data_valid,
   input  logic                  dr_data_ready,
   output logic [DATA_WIDTH-1:0] dr_data,
   input  logic                  dw_data_addr_valid,
   output logic                  dw_data_addr_ready,
   input  logic [ADDR_WIDTH-1:0] dw_addr,
   input  logic [DATA_WIDTH-1:0] dw_data,
   input  logic [STRB_WIDTH-1:0] dw_strobe,
   output logic                  dw_resp_valid,
   input  logic                  dw_resp_ready,
   output logic [RESP_WIDTH-1:0] dw_resp
);

   localparam int MEM_AW = $clog2(MEM_DEPTH);

   // ---------------- address decode ----------------
   logic                  w_rd_hs;
   logic                  w_wr_hs;
   logic [ADDR_WIDTH-1:0] w_rd_word_idx;
   logic [ADDR_WIDTH-1:0] w_wr_word_idx;
   logic                  w_rd_in_range;
   logic                  w_wr_ok;
   logic                  w_unused_rd_lsb;

   assign w_rd_hs = dr_addr_valid && dr_addr_ready;
   assign w_wr_hs = dw_data_addr_valid && dw_data_addr_ready;

   // Full-width word index so addresses beyond the array are caught rather
   // than aliasing onto a low word.
   assign w_rd_word_idx = {2'b00, dr_addr[ADDR_WIDTH-1:2]};
   assign w_wr_word_idx = {2'b00, dw_addr[ADDR_WIDTH-1:2]};
   assign w_rd_in_range = w_rd_word_idx < ADDR_WIDTH'(MEM_DEPTH);
   assign w_wr_ok       = (dw_addr[1:0] == 2'b00) &&
                          (w_wr_word_idx < ADDR_WIDTH'(MEM_DEPTH));

   // Reads are word aligned; the byte offset is simply dropped.
   assign w_unused_rd_lsb = &{1'b0, dr_addr[1:0]};

   // ---------------- storage ----------------
   logic [DATA_WIDTH-1:0] w_ram_q;

   copperv_sram_word_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .STRB_WIDTH (STRB_WIDTH),
      .MEM_AW     (MEM_AW)
   ) u_sram (
      .clk         (clk),
      .i_rd_en     (w_rd_hs && w_rd_in_range),
      .i_rd_addr   (dr_addr[MEM_AW+1:2]),
      .o_rd_data   (w_ram_q),
      .i_wr_en     (w_wr_hs && w_wr_ok),
      .i_wr_addr   (dw_addr[MEM_AW+1:2]),
      .i_wr_data   (dw_data),
      .i_wr_strobe (dw_strobe)
   );

   // ---------------- read FSM ----------------
   bus_resp_state_e r_rd_state;
   bus_resp_state_e w_rd_state_next;
   logic            r_rd_oob;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_state <= bus_resp_idle;
         r_rd_oob   <= 1'b1;
      end else begin
         r_rd_state <= w_rd_state_next;
         if (w_rd_hs) begin
            r_rd_oob <= !w_rd_in_range;
         end
      end
   end

   always_comb begin
      w_rd_state_next = r_rd_state;
      dr_addr_ready   = 1'b0;
      dr_data_valid   = 1'b0;
      case (r_rd_state)
         bus_resp_idle: begin
            dr_addr_ready = 1'b1;
            if (dr_addr_valid) begin
               w_rd_state_next = bus_resp_busy;
            end
         end
         bus_resp_busy: begin
            dr_data_valid = 1'b1;
            if (dr_data_ready) begin
               w_rd_state_next = bus_resp_idle;
            end
         end
         default: w_rd_state_next = bus_resp_idle;
      endcase
   end

   // The RAM output register only moves on an accepted read, so it holds the
   // response through backpressure. Out-of-range reads and the idle state
   // (including straight after reset) present zero.
   assign dr_data = ((r_rd_state == bus_resp_busy) && !r_rd_oob) ?
                    w_ram_q : '0;

   // ---------------- write FSM ----------------
   bus_resp_state_e  r_wr_state;
   bus_resp_state_e  w_wr_state_next;
   data_write_resp_e r_wr_resp;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_state <= bus_resp_idle;
         r_wr_resp  <= data_write_resp_fail;
      end else begin
         r_wr_state <= w_wr_state_next;
         if (w_wr_hs) begin
            r_wr_resp <= w_wr_ok ? data_write_resp_ok : data_write_resp_fail;
         end
      end
   end

   always_comb begin
      w_wr_state_next    = r_wr_state;
      dw_data_addr_ready = 1'b0;
      dw_resp_valid      = 1'b0;
      case (r_wr_state)
         bus_resp_idle: begin
            dw_data_addr_ready = 1'b1;
            if (dw_data_addr_valid) begin
               w_wr_state_next = bus_resp_busy;
            end
         end
         bus_resp_busy: begin
            dw_resp_valid = 1'b1;
            if (dw_resp_ready) begin
               w_wr_state_next = bus_resp_idle;
            end
         end
         default: w_wr_state_next = bus_resp_idle;
      endcase
   end

   assign dw_resp = RESP_WIDTH'(r_wr_resp);

endmodule : copperv_data_responder

// File: doc/copperv_data_responder.md
Name: copperv_data_responder

Overview:
- Memory-side responder for the CPU data bus: serves read-address/read-data and write-data/write-response channels, backed by an internal word SRAM.
- Sits opposite the core's data-bus initiator in sims and small SoC tops.
- Returns write status encoded as data_write_resp_e.
- Read and write channels are independent; each allows one outstanding transaction.

Parameters:
- DATA_WIDTH, 32, bus data width in bits.
- ADDR_WIDTH, 32, bus byte-address width.
- STRB_WIDTH, DATA_WIDTH/8, write byte-strobe width.
- RESP_WIDTH, 1, write response width; holds data_write_resp_e.
- MEM_DEPTH, 1024, number of DATA_WIDTH words; byte range is 0 to MEM_DEPTH*STRB_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- dr_addr_valid  in  1  read address valid.
- dr_addr_ready  out  1  read address accepted.
- dr_addr  in  ADDR_WIDTH  read byte address.
- dr_data_valid  out  1  read data valid.
- dr_data_ready  in  1  initiator accepts read data.
- dr_data  out  DATA_WIDTH  read data.
- dw_data_addr_valid  in  1  write request valid.
- dw_data_addr_ready  out  1  write request accepted.
- dw_addr  in  ADDR_WIDTH  write byte address.
- dw_data  in  DATA_WIDTH  write data.
- dw_strobe  in  STRB_WIDTH  byte enables.
- dw_resp_valid  out  1  write response valid.
- dw_resp_ready  in  1  initiator accepts response.
- dw_resp  out  RESP_WIDTH  data_write_resp_ok or data_write_resp_fail.

Behaviour:
- Reset (rst low, async):
  - both FSMs go to bus_resp_idle.
  - dr_addr_ready=1, dw_data_addr_ready=1, dr_data_valid=0, dw_resp_valid=0.
  - dr_data=0, dw_resp=data_write_resp_fail.
  - SRAM contents are not reset.
- Handshake: transfer occurs on the rising clk edge where valid and ready are both 1.
  - Outputs held stable while valid=1 and ready=0.
  - Valid is never deasserted before the handshake.
- Read FSM:
  - idle (addr_ready=1): on address handshake, capture the word at dr_addr[ADDR_WIDTH-1:2] and go to busy. dr_data_valid=1 the next cycle (latency 1).
  - busy (addr_ready=0): hold dr_data until the data handshake, then return to idle with dr_data_valid=0.
  - No same-cycle re-accept: minimum 2 cycles per read.
  - Out of range (word index >= MEM_DEPTH): dr_data=0.
  - Address bits [1:0] are ignored; reads are word-aligned.
- Write FSM:
  - idle: on request handshake, commit strobed bytes that same edge and go to busy. dw_resp_valid=1 the next cycle with the status.
  - busy: hold dw_resp until the response handshake, then return to idle.
  - Status fail, with no commit: dw_addr[1:0]!=0, or word index >= MEM_DEPTH.
  - Status ok otherwise. dw_strobe=0 returns ok with no change.
- Simultaneous read and write to the same word in one cycle: the read returns the pre-write value (read-before-write).
- Reset mid-transaction: the pending response is dropped and no valid is presented after reset. A write already accepted stays committed.
- The two channels never stall each other.

Decomposition:
- Add to the shared package:
  - typedef bus_resp_state_e {bus_resp_idle, bus_resp_busy}.
  - reuse data_write_resp_e for dw_resp.
- Sub-module copperv_sram_word_array:
  - one synchronous read port, one byte-strobed write port, parameterised by DATA_WIDTH/MEM_DEPTH.
  - read-before-write on address collision.
- Top level holds both FSMs plus range and alignment checks.

Test Plan:
- Basic write/read:
  - write addr 0x10, data 0xCAFEF00D, strobe 4'hF, resp_ready=1 -> dw_resp_valid 1 cycle later, dw_resp=data_write_resp_ok.
  - read 0x10 -> dr_data=0xCAFEF00D, dr_data_valid exactly 1 cycle after the address handshake.
- Byte strobes: word 0x20 holds 0x11223344; write 0xAABBCCDD with strobe 4'b0101 -> read returns 0x11BB33DD.
- Error cases:
  - write addr 0x12 -> resp fail and memory unchanged.
  - write addr MEM_DEPTH*4 -> resp fail.
  - read addr MEM_DEPTH*4 -> dr_data=0.
- Backpressure:
  - hold dr_data_ready=0 for 5 cycles -> dr_data_valid and dr_data stable, dr_addr_ready=0 throughout.
  - the same holds for dw_resp with dw_resp_ready=0.
- Collision: same-cycle read and write to 0x30 (old 0x1, new 0x2) -> read returns 0x1, and a following read returns 0x2.
- Reset while busy: assert rst low with dr_data_valid=1 -> dr_data_valid falls immediately; after release, ready=1 and no spurious valid.
